// File: rtl/des_input_packer.sv
`default_nettype none
// ============================================================================
// Module      : des_input_packer
// Description : Packs a byte stream into 64-bit big-endian blocks and applies
//               PKCS#5 padding before handing each block to a triple-DES core.
// Revision    : 1.0 - initial release
// ============================================================================
module des_input_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    input  logic        flush,
    input  logic        mode_in,
    output logic [63:0] input_data_block,
    output logic        encr_decr,
    output logic        enable,
    input  logic        done,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_PAD   = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    localparam logic [2:0] c_LAST_IDX = 3'd7;

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic        w_in_fill;
    logic        w_byte_accept;
    logic        w_flush_accept;

    // Write one byte into the big-endian slot selected by idx.
    function automatic logic [63:0] f_insert(
        input logic [63:0] blk,
        input logic [2:0]  idx,
        input logic [7:0]  b
    );
        logic [63:0] res;
        res = blk;
        for (int i = 0; i < 8; i++) begin
            if (3'(i) == idx) begin
                res[63-8*i -: 8] = b;
            end
        end
        return res;
    endfunction

    // PKCS#5: every slot from n_held upward takes the value 8 - n_held.
    function automatic logic [63:0] f_pad(
        input logic [63:0] blk,
        input logic [2:0]  n_held
    );
        logic [63:0] res;
        logic [7:0]  pad_val;
        res     = blk;
        pad_val = 8'd8 - {5'd0, n_held};
        for (int i = 0; i < 8; i++) begin
            if (3'(i) >= n_held) begin
                res[63-8*i -: 8] = pad_val;
            end
        end
        return res;
    endfunction

    // A byte always wins over a simultaneous flush, so ready only drops for a lone flush.
    always_comb begin
        w_in_fill      = (r_state == ST_FILL);
        byte_ready     = ~rst & w_in_fill & ~(flush & ~byte_valid);
        w_byte_accept  = byte_valid & byte_ready;
        w_flush_accept = w_in_fill & flush & ~byte_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= ST_FILL;
            r_cnt            <= 3'd0;
            input_data_block <= 64'd0;
            encr_decr        <= 1'b0;
            enable           <= 1'b0;
            busy             <= 1'b0;
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (w_byte_accept) begin
                        input_data_block <= f_insert(input_data_block, r_cnt, byte_in);
                        r_cnt            <= r_cnt + 3'd1;
                        if (r_cnt == 3'd0) begin
                            encr_decr <= mode_in;
                        end
                        if (r_cnt == c_LAST_IDX) begin
                            r_state <= ST_ISSUE;
                            enable  <= 1'b1;
                            busy    <= 1'b1;
                        end
                    end else if (w_flush_accept) begin
                        r_state <= ST_PAD;
                    end
                end
                ST_PAD: begin
                    input_data_block <= f_pad(input_data_block, r_cnt);
                    r_cnt            <= 3'd0;
                    r_state          <= ST_ISSUE;
                    enable           <= 1'b1;
                    busy             <= 1'b1;
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done) begin
                        r_state <= ST_FILL;
                        enable  <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_FILL;
                    r_cnt   <= 3'd0;
                    enable  <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_des_input_packer.sv
`default_nettype none
// Testbench for des_input_packer: directed scenarios plus random messages
// checked against a queue-based PKCS#5 block model.
module tb_des_input_packer;

    logic        tb_clk = 1'b0;
    logic        rst;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        flush;
    logic        mode_in;
    logic [63:0] input_data_block;
    logic        encr_decr;
    logic        enable;
    logic        done;
    logic        busy;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  cur_q[$];
    logic        m_encr;

    always #5 tb_clk = ~tb_clk;

    des_input_packer dut (
        .clk              (tb_clk),
        .rst              (rst),
        .byte_in          (byte_in),
        .byte_valid       (byte_valid),
        .byte_ready       (byte_ready),
        .flush            (flush),
        .mode_in          (mode_in),
        .input_data_block (input_data_block),
        .encr_decr        (encr_decr),
        .enable           (enable),
        .done             (done),
        .busy             (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected block: held bytes in arrival order, remaining slots padded with 8-size.
    function automatic logic [63:0] model_block();
        logic [63:0] r;
        int          sz;
        r  = 64'd0;
        sz = cur_q.size();
        for (int k = 0; k < 8; k++) begin
            r = {r[55:0], (k < sz) ? cur_q[k] : 8'(8 - sz)};
        end
        return r;
    endfunction

    task automatic idle_cycle();
        byte_valid = 1'b0; flush = 1'b0; done = 1'b0;
        @(negedge tb_clk);
    endtask

    // Called just after the issuing edge; optionally holds a byte pending during WAIT.
    task automatic finish_block(input bit bp, input logic [7:0] bp_byte, input logic bp_mode);
        logic [63:0] exp;
        int          lat;
        exp = model_block();
        chk("issue_block", input_data_block, exp);
        chk("issue_enable", enable, 1);
        chk("issue_busy", busy, 1);
        chk("issue_mode", encr_decr, m_encr);
        chk("issue_ready_low", byte_ready, 0);
        done = 1'b1; flush = 1'b1;
        byte_valid = bp; byte_in = bp_byte; mode_in = bp_mode;
        @(negedge tb_clk);
        done = 1'b0; flush = 1'b0;
        chk("done_in_issue_ignored", enable, 1);
        lat = $urandom_range(0, 3);
        repeat (lat) begin
            @(negedge tb_clk);
            chk("wait_block_stable", input_data_block, exp);
            chk("wait_ready_low", byte_ready, 0);
        end
        done = 1'b1;
        @(negedge tb_clk);
        done = 1'b0;
        #1;
        chk("done_enable_drop", enable, 0);
        chk("done_busy_drop", busy, 0);
        chk("done_ready_high", byte_ready, 1);
        chk("done_block_held", input_data_block, exp);
        cur_q.delete();
    endtask

    task automatic push_byte(input logic [7:0] b, input logic m, input logic f);
        byte_valid = 1'b1; byte_in = b; mode_in = m; flush = f; done = 1'b0;
        #1;
        chk("byte_ready_fill", byte_ready, 1);
        @(negedge tb_clk);
        byte_valid = 1'b0; flush = 1'b0;
        if (cur_q.size() == 0) m_encr = m;
        cur_q.push_back(b);
        if (cur_q.size() == 8) finish_block(0, 8'h00, 1'b0);
    endtask

    task automatic do_flush();
        byte_valid = 1'b0; flush = 1'b1; done = 1'b0;
        #1;
        chk("ready_low_on_flush", byte_ready, 0);
        @(negedge tb_clk);
        flush = 1'b0;
        chk("pad_enable_low", enable, 0);
        chk("pad_ready_low", byte_ready, 0);
        @(negedge tb_clk);
        finish_block(0, 8'h00, 1'b0);
    endtask

    initial begin
        logic [7:0] msg1[8];
        logic [7:0] b;
        int         len;
        int         gap;
        logic       m;

        msg1 = '{8'h53, 8'h68, 8'h65, 8'h6C, 8'h6C, 8'h73, 8'h68, 8'h6F};
        rst = 1'b1; byte_in = 8'h00; byte_valid = 1'b0; flush = 1'b0;
        mode_in = 1'b0; done = 1'b0; m_encr = 1'b0;
        #3;
        chk("rst_block", input_data_block, 64'd0);
        chk("rst_enable", enable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_encr", encr_decr, 0);
        chk("rst_ready", byte_ready, 0);
        @(negedge tb_clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", byte_ready, 1);

        // Full block, then back-pressure with a byte pending through WAIT.
        for (int i = 0; i < 7; i++) push_byte(msg1[i], 1'b1, 1'b0);
        byte_valid = 1'b1; byte_in = msg1[7]; mode_in = 1'b1;
        @(negedge tb_clk);
        byte_valid = 1'b0;
        cur_q.push_back(msg1[7]);
        chk("full_block_value", input_data_block, 64'h5368656C6C73686F);
        finish_block(1, 8'hA5, 1'b0);
        push_byte(8'hA5, 1'b0, 1'b0);
        chk("pending_byte_msb", input_data_block[63:56], 8'hA5);
        chk("pending_byte_mode", encr_decr, 0);
        for (int i = 0; i < 7; i++) push_byte(8'(i + 1), 1'b1, 1'b0);

        // Partial flush.
        push_byte(8'h20, 1'b0, 1'b0);
        push_byte(8'h6B, 1'b1, 1'b0);
        push_byte(8'h6E, 1'b1, 1'b0);
        do_flush();
        chk("partial_flush_value", input_data_block, 64'h206B6E0505050505);

        // Empty flush, with a stray done in FILL first.
        done = 1'b1;
        @(negedge tb_clk);
        done = 1'b0;
        chk("done_in_fill_ignored", enable, 0);
        do_flush();
        chk("empty_flush_value", input_data_block, 64'h0808080808080808);

        // Flush together with the eighth byte: no pad block follows.
        for (int i = 0; i < 7; i++) push_byte(msg1[i], 1'b1, 1'b0);
        push_byte(8'h6F, 1'b1, 1'b1);
        repeat (3) begin
            idle_cycle();
            chk("no_pad_after_combined_flush", enable, 0);
        end

        // Reset while waiting on the core.
        for (int i = 0; i < 7; i++) push_byte(msg1[i], 1'b1, 1'b0);
        byte_valid = 1'b1; byte_in = 8'h6F; mode_in = 1'b1;
        @(negedge tb_clk);
        byte_valid = 1'b0;
        chk("pre_rst_enable", enable, 1);
        @(negedge tb_clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_enable", enable, 0);
        chk("async_rst_block", input_data_block, 64'd0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_ready", byte_ready, 0);
        cur_q.delete();
        m_encr = 1'b0;
        @(negedge tb_clk);
        rst = 1'b0;
        done = 1'b1;
        @(negedge tb_clk);
        done = 1'b0;
        #1;
        chk("late_done_ignored_enable", enable, 0);
        chk("late_done_ignored_ready", byte_ready, 1);
        for (int i = 0; i < 8; i++) push_byte(msg1[i], 1'b0, 1'b0);

        // Random messages, each terminated by a flush.
        for (int t = 0; t < 20; t++) begin
            len = $urandom_range(0, 17);
            for (int i = 0; i < len; i++) begin
                gap = $urandom_range(0, 2);
                repeat (gap) idle_cycle();
                b = 8'($urandom);
                m = 1'($urandom);
                push_byte(b, m, 1'b0);
            end
            do_flush();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/des_input_packer.md
DES_INPUT_PACKER -- requirements
Module: des_input_packer

Interface
REQ-001 SHALL have a single clock domain: clk.
REQ-002 SHALL use an asynchronous, active-high reset named rst.
REQ-003 Ports SHALL be exactly as follows (name, direction, width, meaning):
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- byte_in, input, 8, plaintext/ciphertext byte from the upstream source.
- byte_valid, input, 1, byte_in is valid this cycle.
- byte_ready, output, 1, packer accepts byte_in this cycle.
- flush, input, 1, end-of-message pulse; pad and issue the final block.
- mode_in, input, 1, 1 = encrypt, 0 = decrypt; sampled with the first byte of each block.
- input_data_block, output, 64, assembled block to the triple-DES core.
- encr_decr, output, 1, latched mode for the current block.
- enable, output, 1, block request to the triple-DES core.
- done, input, 1, triple-DES core has finished the current block.
- busy, output, 1, a block is issued and not yet completed.

Function
REQ-004 SHALL implement four states:
- FILL: collect bytes.
- PAD: apply padding, exactly 1 cycle.
- ISSUE: assert enable.
- WAIT: hold until done.
REQ-005 SHALL keep a 3-bit byte counter, cnt, of bytes held in the current block (0..7).
REQ-006 A byte SHALL be accepted only when byte_valid and byte_ready are both high at a rising clk edge.
REQ-007 byte_ready SHALL be high only in FILL, and SHALL be low in the cycle flush is accepted.
REQ-008 Byte placement SHALL be big-endian: the byte accepted at count k goes to input_data_block[63-8k -: 8]. The first byte lands in bits [63:56].
REQ-009 mode_in SHALL be latched into encr_decr when the byte at count 0 is accepted. encr_decr SHALL hold until the next count-0 acceptance.
REQ-010 When the 8th byte is accepted (cnt 7), the FSM SHALL go to ISSUE and cnt SHALL wrap to 0.
REQ-011 In FILL, flush=1 with no byte accepted SHALL go to PAD.
REQ-012 flush=1 and an accepted byte in the same cycle SHALL count as a byte accept only. flush is ignored in that cycle and must be re-asserted.
REQ-013 flush outside FILL SHALL be ignored.
REQ-014 PAD SHALL use PKCS#5 padding with N = 8 - cnt. The N bytes at positions cnt..7 are each set to value N.
REQ-015 A flush with cnt = 0 SHALL produce the block 0808080808080808. PAD then goes to ISSUE.
REQ-016 enable SHALL be high in ISSUE and WAIT, and low otherwise. It rises 1 cycle after the 8th byte is accepted, or 1 cycle after PAD.
REQ-017 ISSUE SHALL last exactly 1 cycle, then go to WAIT.
REQ-018 input_data_block and encr_decr SHALL remain stable from entry to ISSUE until leaving WAIT.
REQ-019 In WAIT, done=1 SHALL go to FILL on the next edge, so enable drops 1 cycle after done.
REQ-020 done sampled in ISSUE, or in FILL/PAD, SHALL be ignored.
REQ-021 busy SHALL equal (state == ISSUE or state == WAIT).
REQ-022 Throughput SHALL be at best 8 accept cycles + 1 ISSUE cycle + core latency + 1 cycle per block.

Reset
REQ-023 rst=1 SHALL immediately, without waiting for clk, force:
- state = FILL, cnt = 0;
- input_data_block = 0, encr_decr = 0;
- enable = 0, busy = 0;
- byte_ready = 0 while rst is high.
REQ-024 The first clk edge after rst deasserts SHALL see byte_ready = 1.
REQ-025 rst asserted mid-block or in WAIT SHALL discard the partial block. Any later done SHALL be ignored.

Verification
REQ-026 Full block: mode_in=1, bytes 53 68 65 6C 6C 73 68 6F on consecutive cycles.
- Next cycle: input_data_block = 5368656C6C73686F, enable = 1, encr_decr = 1, byte_ready = 0.
REQ-027 Back-pressure: hold byte_valid=1 during WAIT.
- No byte is consumed.
- After done pulses, enable drops 1 cycle later, then byte_ready = 1 and the pending byte lands in [63:56].
REQ-028 Partial flush: bytes 20 6B 6E, then a flush pulse.
- After the PAD cycle: block = 206B6E0505050505, enable = 1.
REQ-029 Empty flush: a flush pulse with cnt = 0.
- Block = 0808080808080808, enable rises 2 cycles after flush.
REQ-030 Flush and byte together: flush with the 8th byte 6F.
- A normal block is issued with no pad block. The flush is dropped.
REQ-031 Reset mid-operation: rst pulse in WAIT.
- enable = 0 and block = 0 asynchronously.
- A later done pulse causes no state change.
- A fresh 8-byte sequence issues correctly.
